// File: rtl/st7735_pkg.sv
// Shared types and constants for the ST7735 pixel fill path.
// Colour stepping in the sequencer is enabled by defining ST7735_FILL_STEP_EN.
package st7735_pkg;

  localparam int RGB565_W   = 16;
  localparam int LCD_WIDTH  = 128;
  localparam int LCD_HEIGHT = 160;

  localparam logic [RGB565_W-1:0] COLOR_BLACK = 16'h0000;
  localparam logic [RGB565_W-1:0] COLOR_WHITE = 16'hFFFF;
  localparam logic [RGB565_W-1:0] COLOR_RED   = 16'hF800;
  localparam logic [RGB565_W-1:0] COLOR_GREEN = 16'h07E0;
  localparam logic [RGB565_W-1:0] COLOR_BLUE  = 16'h001F;

  typedef enum logic [1:0] {
    FILL_IDLE      = 2'd0,
    FILL_WAIT_LCD  = 2'd1,
    FILL_WAIT_ACK  = 2'd2,
    FILL_WAIT_DONE = 2'd3
  } fill_state_e;

  // Wraps silently modulo 2^16.
  function automatic logic [RGB565_W-1:0] rgb565_add(
    input logic [RGB565_W-1:0] a,
    input logic [RGB565_W-1:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/st7735_fill_sequencer_fill_ack_timer.sv
// Acknowledge timeout: down-counter loaded on every pixel strobe, expires at zero.
module fill_ack_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= LOAD_VAL;
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = i_enable && (r_cnt == '0);

endmodule

// File: rtl/st7735_fill_sequencer.sv
// Command-driven ST7735 pixel scheduler: fills N pixels, paced by LCD_READY/IS_BUSY.
// Define ST7735_FILL_STEP_EN to add CMD_STEP to the colour after every pixel.
//
// state          | meaning
// FILL_IDLE      | ready for a command
// FILL_WAIT_LCD  | waiting for driver ready and not busy, then strobe the pixel
// FILL_WAIT_ACK  | pixel strobed, waiting for IS_BUSY to rise (timed)
// FILL_WAIT_DONE | driver shifting the pixel, waiting for IS_BUSY to fall
module st7735_fill_sequencer
  import st7735_pkg::*;
#(
  parameter int COUNT_W     = 15,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                SYSTEM_CLK,
  input  logic                RESET_N,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic [COUNT_W-1:0]  CMD_COUNT,
  input  logic [RGB565_W-1:0] CMD_COLOR,
  input  logic [RGB565_W-1:0] CMD_STEP,
  input  logic                ABORT,
  input  logic                LCD_READY,
  input  logic                IS_BUSY,
  output logic [RGB565_W-1:0] color_pixel,
  output logic                WRITE_EN,
  output logic                ACTIVE,
  output logic                DONE,
  output logic                RETRY,
  output logic [COUNT_W-1:0]  PIXELS_LEFT
);

  fill_state_e r_state, w_state_nxt;

  logic                r_cmd_ready,   w_cmd_ready_nxt;
  logic                r_write_en,    w_write_en_nxt;
  logic                r_done,        w_done_nxt;
  logic                r_retry,       w_retry_nxt;
  logic                r_active,      w_active_nxt;
  logic [COUNT_W-1:0]  r_pixels_left, w_pixels_nxt;
  logic [RGB565_W-1:0] r_color,       w_color_nxt;
  logic [RGB565_W-1:0] r_color_pixel, w_color_pixel_nxt;

  logic w_timer_en;
  logic w_ack_expire;

`ifdef ST7735_FILL_STEP_EN
  logic [RGB565_W-1:0] r_step, w_step_nxt;
`else
  logic w_unused_step;
  assign w_unused_step = ^CMD_STEP;
`endif

  assign w_timer_en = (r_state == FILL_WAIT_ACK);

  fill_ack_timer #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .i_clk    (SYSTEM_CLK),
    .i_rst_n  (RESET_N),
    .i_clear  (w_write_en_nxt),
    .i_enable (w_timer_en),
    .o_expire (w_ack_expire)
  );

  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= FILL_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cmd_ready_nxt   = r_cmd_ready;
    w_write_en_nxt    = 1'b0;
    w_done_nxt        = 1'b0;
    w_retry_nxt       = 1'b0;
    w_active_nxt      = r_active;
    w_pixels_nxt      = r_pixels_left;
    w_color_nxt       = r_color;
    w_color_pixel_nxt = r_color_pixel;
`ifdef ST7735_FILL_STEP_EN
    w_step_nxt        = r_step;
`endif

    case (r_state)
      FILL_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        w_active_nxt    = 1'b0;
        if (CMD_VALID && r_cmd_ready) begin
          w_color_nxt = CMD_COLOR;
`ifdef ST7735_FILL_STEP_EN
          w_step_nxt  = CMD_STEP;
`endif
          if (CMD_COUNT == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt     = FILL_WAIT_LCD;
            w_active_nxt    = 1'b1;
            w_cmd_ready_nxt = 1'b0;
            w_pixels_nxt    = CMD_COUNT;
          end
        end
      end

      // No timeout here: a driver that drops LCD_READY simply stalls us.
      FILL_WAIT_LCD: begin
        if (LCD_READY && !IS_BUSY) begin
          w_write_en_nxt    = 1'b1;
          w_color_pixel_nxt = r_color;
          w_state_nxt       = FILL_WAIT_ACK;
        end
      end

      FILL_WAIT_ACK: begin
        if (IS_BUSY) begin
          w_state_nxt = FILL_WAIT_DONE;
        end else if (w_ack_expire) begin
          w_retry_nxt = 1'b1;
          w_state_nxt = FILL_WAIT_LCD;
        end
      end

      FILL_WAIT_DONE: begin
        if (!IS_BUSY) begin
          w_pixels_nxt = r_pixels_left - COUNT_W'(1);
          if (r_pixels_left == COUNT_W'(1)) begin
            w_done_nxt      = 1'b1;
            w_active_nxt    = 1'b0;
            w_cmd_ready_nxt = 1'b1;
            w_state_nxt     = FILL_IDLE;
          end else begin
`ifdef ST7735_FILL_STEP_EN
            w_color_nxt = rgb565_add(r_color, r_step);
`endif
            w_state_nxt = FILL_WAIT_LCD;
          end
        end
      end

      default: begin
        w_state_nxt = FILL_IDLE;
      end
    endcase

    // Abort wins over everything once a command is running; a pixel already
    // handed to the driver is left to finish on its own.
    if (ABORT && (r_state != FILL_IDLE)) begin
      w_state_nxt     = FILL_IDLE;
      w_done_nxt      = 1'b1;
      w_retry_nxt     = 1'b0;
      w_write_en_nxt  = 1'b0;
      w_active_nxt    = 1'b0;
      w_cmd_ready_nxt = 1'b1;
      w_pixels_nxt    = '0;
    end
  end

  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cmd_ready   <= 1'b1;
      r_write_en    <= 1'b0;
      r_done        <= 1'b0;
      r_retry       <= 1'b0;
      r_active      <= 1'b0;
      r_pixels_left <= '0;
      r_color       <= COLOR_BLACK;
      r_color_pixel <= COLOR_BLACK;
    end else begin
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_write_en    <= w_write_en_nxt;
      r_done        <= w_done_nxt;
      r_retry       <= w_retry_nxt;
      r_active      <= w_active_nxt;
      r_pixels_left <= w_pixels_nxt;
      r_color       <= w_color_nxt;
      r_color_pixel <= w_color_pixel_nxt;
    end
  end

`ifdef ST7735_FILL_STEP_EN
  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_step <= '0;
    end else begin
      r_step <= w_step_nxt;
    end
  end
`endif

  assign CMD_READY   = r_cmd_ready;
  assign WRITE_EN    = r_write_en;
  assign DONE        = r_done;
  assign RETRY       = r_retry;
  assign ACTIVE      = r_active;
  assign PIXELS_LEFT = r_pixels_left;
  assign color_pixel = r_color_pixel;

endmodule
